// File: rtl/inst_cache_dm.sv
// inst_cache_dm: direct-mapped read-only instruction cache with a word-by-word line fill and hit/miss counters
module inst_cache_dm #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_fault,
  input  logic                  inv,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  state_t state, state_nx;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [31:0] data [NUM_LINES*WORDS_PER_LINE];
  logic [ADDR_WIDTH-3:0] lat;
  logic [OFF_W-1:0] k;
  logic inv_pend, accept, misal, hit, last_ack;
  logic [TAG_W-1:0] a_tag, l_tag;
  logic [IDX_W-1:0] a_idx, l_idx;
  logic [OFF_W-1:0] a_word, l_word;
  assign a_tag  = cpu_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
  assign a_idx  = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign a_word = cpu_addr[OFF_W+1:2];
  assign l_tag  = lat[ADDR_WIDTH-3:IDX_W+OFF_W];
  assign l_idx  = lat[IDX_W+OFF_W-1:OFF_W];
  assign l_word = lat[OFF_W-1:0];
  // A pending invalidate blocks accepts for the one cycle it spends clearing the valid bits
  assign cpu_ready = state == IDLE && !inv && !inv_pend;
  assign accept    = cpu_req && cpu_ready;
  assign misal     = |cpu_addr[1:0];
  assign hit       = valid[a_idx] && tags[a_idx] == a_tag;
  assign last_ack  = state == FILL && mem_ack && &k;
  assign mem_req   = state == FILL;
  assign mem_addr  = mem_req ? {lat[ADDR_WIDTH-3:OFF_W], k, 2'b00} : '0;
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept && !misal && !hit) state_nx = FILL;
    if (last_ack) state_nx = RESP;
    if (state == RESP) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= '0;
      lat        <= '0;
      k          <= '0;
      inv_pend   <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_fault  <= 1'b0;
      cpu_rdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= state_nx;
      cpu_rvalid <= (accept && (misal || hit)) || state == RESP;
      cpu_fault  <= accept && misal;
      cpu_rdata  <= state == RESP ? data[{l_idx, l_word}] :
                    (accept && !misal && hit) ? data[{a_idx, a_word}] : '0;
      if (accept && !misal && hit && !(&hit_count)) hit_count <= hit_count + 32'd1;
      if (accept && !misal && !hit) begin
        lat <= cpu_addr[ADDR_WIDTH-1:2];
        if (!(&miss_count)) miss_count <= miss_count + 32'd1;
      end
      if (state == FILL && mem_ack) k <= k + 1'b1;
      if (last_ack) valid[l_idx] <= 1'b1;
      if (state == IDLE && (inv || inv_pend)) valid <= '0;
      inv_pend <= state != IDLE && (inv_pend || inv);
    end
  end
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) begin
      data[{l_idx, k}] <= mem_rdata;
      if (&k) tags[l_idx] <= l_tag;
    end
  end
endmodule

// File: tb/tb_inst_cache_dm.sv
// tb_inst_cache_dm: directed tests of inst_cache_dm against a memory returning addr + 0x1000_0000
module tb_inst_cache_dm;
  logic clk = 0, rst = 0, cpu_req = 0, inv = 0, ack_force = 0;
  logic [31:0] cpu_addr = 0;
  logic cpu_ready, cpu_rvalid, cpu_fault, mem_req, mem_ack;
  logic [31:0] cpu_rdata, mem_addr, mem_rdata, hit_count, miss_count;
  int n_checks = 0, n_fail = 0, ack_lat = 1, cnt = 0, mem_req_cyc = 0;
  logic [31:0] mem_log [$];

  inst_cache_dm dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  assign mem_ack   = ack_force || (mem_req && cnt == ack_lat - 1);
  assign mem_rdata = mem_addr + 32'h1000_0000;
  always @(posedge clk) begin
    cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
    if (mem_req) mem_req_cyc <= mem_req_cyc + 1;
    if (mem_req && mem_ack) mem_log.push_back(mem_addr);
  end

  task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] d, output logic f);
    int n = 0;
    @(negedge clk);
    cpu_req = 1; cpu_addr = a;
    while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
    cyc = 0;
    do begin @(negedge clk); cpu_req = 0; cyc++; end while (!cpu_rvalid && cyc < 50);
    d = cpu_rdata; f = cpu_fault;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", name, got, exp); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cpu_ready); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", cpu_rvalid); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_count, miss_count); end
  endtask

  task automatic test_cold_miss;
    int cyc; logic [31:0] d; logic f;
    logic [31:0] exp_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    ack_lat = 1; mem_log.delete();
    fetch(32'h104, cyc, d, f);
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL cold_latency: got %0d expected 6", cyc); end
    n_checks++; if (d !== 32'h1000_0104 || f !== 1'b0) begin n_fail++; $display("FAIL cold_data: got %h/%b expected 10000104/0", d, f); end
    n_checks++; if (mem_log.size() != 4) begin n_fail++; $display("FAIL cold_fill_len: got %0d expected 4", mem_log.size()); end
    for (int i = 0; i < 4 && i < mem_log.size(); i++) begin
      n_checks++; if (mem_log[i] !== exp_addr[i]) begin n_fail++; $display("FAIL cold_mem_addr%0d: got %h expected %h", i, mem_log[i], exp_addr[i]); end
    end
    n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_miss_count: got %0d expected 1", miss_count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3] = '{32'h100, 32'h108, 32'h10C};
    int req0 = mem_req_cyc;
    @(negedge clk);
    cpu_req = 1; cpu_addr = addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) cpu_addr = addrs[i+1]; else cpu_req = 0;
      n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== addrs[i] + 32'h1000_0000) begin n_fail++; $display("FAIL b2b_hit%0d: got %b/%h expected 1/%h", i, cpu_rvalid, cpu_rdata, addrs[i] + 32'h1000_0000); end
    end
    n_checks++; if (mem_req_cyc != req0) begin n_fail++; $display("FAIL b2b_no_mem: got %0d expected %0d", mem_req_cyc, req0); end
    n_checks++; if (hit_count !== 32'd3) begin n_fail++; $display("FAIL b2b_hit_count: got %0d expected 3", hit_count); end
  endtask

  task automatic test_conflict;
    int cyc; logic [31:0] d; logic f;
    logic [31:0] seq [3] = '{32'h104, 32'h504, 32'h104};
    @(negedge clk);
    inv = 1;
    #1;
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL idle_inv_ready: got %b expected 0", cpu_ready); end
    @(negedge clk);
    inv = 0;
    foreach (seq[i]) begin
      fetch(seq[i], cyc, d, f);
      n_checks++; if (cyc !== 6 || d !== seq[i] + 32'h1000_0000) begin n_fail++; $display("FAIL conflict%0d: got cyc %0d data %h expected cyc 6 data %h", i, cyc, d, seq[i] + 32'h1000_0000); end
    end
    n_checks++; if (miss_count !== 32'd4) begin n_fail++; $display("FAIL conflict_miss_count: got %0d expected 4", miss_count); end
    fetch(32'h10C, cyc, d, f);
    n_checks++; if (cyc !== 1 || d !== 32'h1000_010C || hit_count !== 32'd4) begin n_fail++; $display("FAIL conflict_rehit: got cyc %0d data %h hits %0d expected 1 1000010c 4", cyc, d, hit_count); end
  endtask

  task automatic test_misaligned;
    int cyc; logic [31:0] d; logic f;
    int req0 = mem_req_cyc;
    fetch(32'h102, cyc, d, f);
    n_checks++; if (cyc !== 1 || f !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL misaligned: got cyc %0d fault %b data %h expected 1 1 0", cyc, f, d); end
    n_checks++; if (mem_req_cyc != req0 || hit_count !== 32'd4 || miss_count !== 32'd4) begin n_fail++; $display("FAIL misaligned_side: got req %0d hits %0d misses %0d expected %0d 4 4", mem_req_cyc, hit_count, miss_count, req0); end
  endtask

  task automatic test_inv_mid_fill;
    int cyc; logic [31:0] d; logic f;
    ack_lat = 3;
    fork
      fetch(32'h204, cyc, d, f);
      begin repeat (4) @(negedge clk); inv = 1; @(negedge clk); inv = 0; end
    join
    n_checks++; if (cyc !== 14 || d !== 32'h1000_0204) begin n_fail++; $display("FAIL inv_fill: got cyc %0d data %h expected 14 10000204", cyc, d); end
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL inv_pending_ready: got %b expected 0", cpu_ready); end
    fetch(32'h204, cyc, d, f);
    n_checks++; if (cyc !== 14 || d !== 32'h1000_0204 || miss_count !== 32'd6) begin n_fail++; $display("FAIL inv_refetch: got cyc %0d data %h misses %0d expected 14 10000204 6", cyc, d, miss_count); end
  endtask

  task automatic test_stray_ack;
    int cyc; logic [31:0] d; logic f;
    @(negedge clk);
    ack_force = 1;
    repeat (2) @(negedge clk);
    ack_force = 0;
    n_checks++; if (mem_req !== 1'b0 || miss_count !== 32'd6 || cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got req %b misses %0d rvalid %b expected 0 6 0", mem_req, miss_count, cpu_rvalid); end
    fetch(32'h208, cyc, d, f);
    n_checks++; if (cyc !== 1 || d !== 32'h1000_0208) begin n_fail++; $display("FAIL stray_ack_hit: got cyc %0d data %h expected 1 10000208", cyc, d); end
  endtask

  task automatic test_reset_mid_fill;
    int cyc; logic [31:0] d; logic f;
    @(negedge clk);
    cpu_req = 1; cpu_addr = 32'h304;
    @(negedge clk);
    cpu_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_fill_word1", mem_addr, 32'h304);
    #2 rst = 0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
    chk("rst_hit_count", hit_count, 32'h0);
    @(negedge clk);
    rst = 1;
    ack_lat = 1;
    fetch(32'h304, cyc, d, f);
    n_checks++; if (cyc !== 6 || d !== 32'h1000_0304 || miss_count !== 32'd1) begin n_fail++; $display("FAIL rst_refetch: got cyc %0d data %h misses %0d expected 6 10000304 1", cyc, d, miss_count); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_misaligned();
    test_inv_mid_fill();
    test_stray_ack();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_cache_dm.md
Name: inst_cache_dm

Overview:
- Direct-mapped, read-only instruction cache in front of the instruction backing memory.
- Successor to the flat byte-array instruction store: parametrised line count and line size, with valid/tag storage and a miss-fill state machine.
- Adds a valid/ready request handshake, a whole-cache invalidate and hit/miss counters.
- Sits between the fetch stage (cpu_* ports) and the memory interconnect (mem_* ports).

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, >=2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2.
- ADDR_WIDTH, 32, byte-address width.
- Derived: OFF_W = log2(WORDS_PER_LINE); IDX_W = log2(NUM_LINES); TAG_W = ADDR_WIDTH-IDX_W-OFF_W-2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_WIDTH  fetch byte address.
- cpu_ready  out  1  request accepted when cpu_req && cpu_ready.
- cpu_rvalid  out  1  one-cycle response pulse.
- cpu_rdata  out  32  instruction word; valid only while cpu_rvalid.
- cpu_fault  out  1  misaligned fetch; qualifies cpu_rvalid.
- inv  in  1  invalidate all lines.
- mem_req  out  1  backing-memory word read request.
- mem_addr  out  ADDR_WIDTH  word-aligned read address.
- mem_ack  in  1  read complete; mem_rdata valid this cycle.
- mem_rdata  in  32  read data.
- hit_count  out  32  hits since reset; saturates at 0xFFFFFFFF.
- miss_count  out  32  misses since reset; saturates at 0xFFFFFFFF.

Behaviour:
- Address split: tag = addr[ADDR_WIDTH-1 : IDX_W+OFF_W+2], index = addr[IDX_W+OFF_W+1 : OFF_W+2], word = addr[OFF_W+1 : 2].
- Reset (rst low, asynchronous):
  - State goes to IDLE; all valid bits are cleared.
  - cpu_rvalid=0, cpu_fault=0, cpu_rdata=0, mem_req=0, mem_addr=0, counters=0.
  - cpu_ready=1 after rst is released.
  - Tag/data arrays are not reset.
  - Reset mid-fill abandons the fill and discards the partial line; mem_req drops immediately.
- IDLE:
  - cpu_ready = !inv.
  - If inv=1: clear all valid bits and accept no request this cycle.
  - Misaligned accept (cpu_addr[1:0]!=0): next cycle cpu_rvalid=1, cpu_fault=1, cpu_rdata=0. No fill; counters unchanged.
  - Hit (valid[idx] and tag match): next cycle cpu_rvalid=1, cpu_rdata = data[idx][word]. hit_count++. Stay in IDLE, so back-to-back hits give one response per cycle.
  - Miss: latch the address, miss_count++, go to FILL. cpu_ready=0 from the next cycle.
- FILL:
  - mem_req=1, mem_addr = {line base, k, 2'b00}, k = 0..WORDS_PER_LINE-1.
  - mem_req and mem_addr are held until mem_ack.
  - On mem_ack, write mem_rdata into data[idx][k] and increment k. The next address appears the following cycle.
  - On the last ack: write the tag, set valid[idx]=1, drop mem_req, go to RESP.
- RESP: cpu_rvalid=1, cpu_rdata = data[idx][word] (requested word), then IDLE.
- Miss latency: accept cycle N, first mem_req at N+1. With 1-cycle acks, the response comes at N+WORDS_PER_LINE+2.
- mem_ack while mem_req=0 is ignored.
- inv during FILL/RESP is latched as pending:
  - The fill and its response complete normally.
  - All valid bits are cleared on the return to IDLE, in the same cycle cpu_ready=0; accepts resume the following cycle.
- Counters saturate; there is no wrap.

Test Plan:
- Cold miss, 1-cycle acks, NUM_LINES=16/WORDS_PER_LINE=4, fetch 0x0000_0104:
  - Expect mem_addr 0x100, 0x104, 0x108, 0x10C.
  - Expect cpu_rvalid 6 cycles after accept with mem word @0x104.
  - Expect miss_count=1.
- Then fetch 0x100, 0x108, 0x10C back-to-back: three consecutive cpu_rvalid cycles, correct words, no mem_req, hit_count=3.
- Conflict: fetch 0x104 then 0x504 (same index, different tag) then 0x104: three misses, each line refilled, data correct.
- Fetch 0x0000_0102: cpu_rvalid=1 and cpu_fault=1 next cycle, cpu_rdata=0, no mem_req, counters unchanged.
- inv pulsed mid-fill (with 3-cycle ack delays):
  - Fill completes and the response is correct.
  - The next fetch to the same line misses again.
- rst low during the 2nd fill word: mem_req drops asynchronously, counters read 0, and a refetch of the same address misses.
